// File: rtl/sseg_scan_decoder_if.sv
// Signal bundle between a multiplexed 7-segment scan source and the scan decoder.
// The master drives the bus and clears errors. The slave is the decoder that reports the rebuilt digits.
interface sseg_scan_decoder_if;
    logic [3:0]  an_in;
    logic [7:0]  sseg_in;
    logic        clr_err;
    logic [15:0] hex_out;
    logic [3:0]  dp_out;
    logic [3:0]  blank_out;
    logic [3:0]  is_h_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        hi_detect;
    logic        glyph_err;
    logic        an_err;
    logic        scan_timeout;

    modport master (
        output an_in, sseg_in, clr_err,
        input  hex_out, dp_out, blank_out, is_h_out, digit_valid,
        input  frame_done, hi_detect, glyph_err, an_err, scan_timeout
    );

    modport slave (
        input  an_in, sseg_in, clr_err,
        output hex_out, dp_out, blank_out, is_h_out, digit_valid,
        output frame_done, hi_detect, glyph_err, an_err, scan_timeout
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and waits for each digit slot to settle.
// It decodes every glyph back to a hex value, rebuilds the four digit registers, and flags frames, errors and timeouts.
module sseg_scan_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT_W     = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    sseg_scan_decoder_if.slave  bus
);
    localparam int                   CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]     CNT_SAT  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TO_MAX   = '1;

    typedef enum logic {IDLE, SCAN} state_t;

    logic [11:0]          syncA_q, syncB_q, prev_q;
    logic [CNT_W-1:0]     stableCnt_q, stableCnt_d;
    logic [TIMEOUT_W-1:0] toCnt_q;
    state_t               state_q;

    logic [15:0] hex_q, hex_d;
    logic [3:0]  dp_q, dp_d, blank_q, blank_d, isH_q, isH_d, valid_q, valid_d, seen_q, seen_d;
    logic        frameDone_q, hiDetect_q, hiDetect_d, glyphErr_q, anErr_q, timeout_q;

    logic [3:0]  sampleAn;
    logic [6:0]  sampleSeg;
    logic        sampleDp, sameSample, capture, anLegal, anBad, legalCap, glyphNew;
    logic        isBlank, isH, hexHit;
    logic [3:0]  hexVal, hexLsb;
    logic [1:0]  digitIdx;

    function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0;
        endcase
        return r;
    endfunction

    // Synchronizer flops start from the idle bus image, so coming out of reset never looks like a stable illegal sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            syncA_q     <= '1;
            syncB_q     <= '1;
            prev_q      <= '1;
            stableCnt_q <= '0;
        end else begin
            syncA_q     <= {bus.an_in, bus.sseg_in};
            syncB_q     <= syncA_q;
            prev_q      <= syncB_q;
            stableCnt_q <= stableCnt_d;
        end
    end

    assign sampleAn   = syncB_q[11:8];
    assign sampleDp   = syncB_q[7];
    assign sampleSeg  = syncB_q[6:0];
    assign sameSample = (syncB_q == prev_q);
    assign stableCnt_d = !sameSample ? '0 :
                         (stableCnt_q == CNT_SAT) ? CNT_SAT : stableCnt_q + 1'b1;
    // The count saturates above the fire value, so each stable run captures exactly once.
    assign capture    = sameSample && (stableCnt_d == CNT_FIRE);

    always_comb begin
        anLegal  = 1'b1;
        digitIdx = 2'd0;
        case (sampleAn)
            4'b1110: digitIdx = 2'd0;
            4'b1101: digitIdx = 2'd1;
            4'b1011: digitIdx = 2'd2;
            4'b0111: digitIdx = 2'd3;
            default: anLegal  = 1'b0;
        endcase
    end

    assign legalCap         = capture && anLegal;
    assign anBad            = capture && !anLegal && (sampleAn != 4'b1111);
    assign {hexHit, hexVal} = decodeGlyph(sampleSeg);
    assign isBlank          = (sampleSeg == 7'b1111111);
    assign isH              = (sampleSeg == 7'b1001000);
    assign hexLsb           = {digitIdx, 2'b00};

    always_comb begin
        hex_d    = hex_q;
        dp_d     = dp_q;
        blank_d  = blank_q;
        isH_d    = isH_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        glyphNew = 1'b0;
        if (legalCap) begin
            dp_d[digitIdx]    = sampleDp;
            blank_d[digitIdx] = isBlank;
            isH_d[digitIdx]   = isH;
            valid_d[digitIdx] = hexHit;
            seen_d[digitIdx]  = 1'b1;
            glyphNew          = !hexHit && !isBlank && !isH;
            if (hexHit) begin
                hex_d[hexLsb +: 4] = hexVal;
            end
        end
        hiDetect_d = blank_d[3] & isH_d[2] & valid_d[1] & (hex_d[7:4] == 4'h1) & blank_d[0];
    end

    // A legal capture outranks an expiring timeout in the same cycle, because it is fresh evidence that the bus is alive.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            hex_q       <= '0;
            dp_q        <= '0;
            blank_q     <= '0;
            isH_q       <= '0;
            valid_q     <= '0;
            seen_q      <= '0;
            toCnt_q     <= '0;
            frameDone_q <= 1'b0;
            hiDetect_q  <= 1'b0;
            glyphErr_q  <= 1'b0;
            anErr_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            glyphErr_q  <= (glyphErr_q & ~bus.clr_err) | glyphNew;
            anErr_q     <= (anErr_q & ~bus.clr_err) | anBad;
            if (legalCap) begin
                hex_q     <= hex_d;
                dp_q      <= dp_d;
                blank_q   <= blank_d;
                isH_q     <= isH_d;
                valid_q   <= valid_d;
                toCnt_q   <= '0;
                timeout_q <= 1'b0;
                state_q   <= SCAN;
                if (state_q == SCAN && seen_d == 4'b1111) begin
                    frameDone_q <= 1'b1;
                    seen_q      <= '0;
                    hiDetect_q  <= hiDetect_d;
                end else begin
                    seen_q <= seen_d;
                end
            end else if (toCnt_q == TO_MAX) begin
                timeout_q  <= 1'b1;
                valid_q    <= '0;
                seen_q     <= '0;
                hiDetect_q <= 1'b0;
                state_q    <= IDLE;
            end else begin
                toCnt_q <= toCnt_q + 1'b1;
            end
        end
    end

    assign bus.hex_out      = hex_q;
    assign bus.dp_out       = dp_q;
    assign bus.blank_out    = blank_q;
    assign bus.is_h_out     = isH_q;
    assign bus.digit_valid  = valid_q;
    assign bus.frame_done   = frameDone_q;
    assign bus.hi_detect    = hiDetect_q;
    assign bus.glyph_err    = glyphErr_q;
    assign bus.an_err       = anErr_q;
    assign bus.scan_timeout = timeout_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder. The bench drives the scan bus through the interface and checks hand-computed results.
module tb_sseg_scan_decoder;
    localparam int SC   = 16;
    localparam int TW   = 8;
    localparam int SLOT = SC + 4;

    logic clk = 1'b0;
    logic reset_n;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   framePulses = 0;

    sseg_scan_decoder_if bus ();

    sseg_scan_decoder #(.STABLE_CYCLES(SC), .TIMEOUT_W(TW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Advance whole cycles and sample on the falling edge, counting frame_done pulses as they appear.
    task automatic stepCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.frame_done === 1'b1) framePulses++;
        end
    endtask

    task automatic runSlot(input logic [3:0] an, input logic [7:0] sseg, input int cycles);
        bus.an_in   = an;
        bus.sseg_in = sseg;
        stepCycles(cycles);
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        bus.an_in   = 4'b1111;
        bus.sseg_in = 8'hFF;
        bus.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (bus.hex_out !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_hex: got %h expected 0000", bus.hex_out);
        end
        testsRun++;
        if ({bus.dp_out, bus.blank_out, bus.is_h_out, bus.digit_valid} !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_vectors: got %h expected 0000",
                     {bus.dp_out, bus.blank_out, bus.is_h_out, bus.digit_valid});
        end
        testsRun++;
        if ({bus.frame_done, bus.hi_detect, bus.glyph_err, bus.an_err, bus.scan_timeout} !== 5'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {bus.frame_done, bus.hi_detect, bus.glyph_err, bus.an_err, bus.scan_timeout});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_capture();
        framePulses = 0;
        bus.an_in   = 4'b1110;
        bus.sseg_in = 8'b1_0000110;
        stepCycles(SC + 1);
        testsRun++;
        if (bus.digit_valid !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL single_early: got %b expected 0000", bus.digit_valid);
        end
        stepCycles(1);
        testsRun++;
        if (bus.digit_valid !== 4'b0001) begin
            testsFailed++;
            $display("[TB] FAIL single_valid: got %b expected 0001", bus.digit_valid);
        end
        testsRun++;
        if (bus.hex_out[3:0] !== 4'h3) begin
            testsFailed++;
            $display("[TB] FAIL single_hex: got %h expected 3", bus.hex_out[3:0]);
        end
        testsRun++;
        if (bus.dp_out[0] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL single_dp: got %b expected 1", bus.dp_out[0]);
        end
        stepCycles(40 - SC - 2);
        testsRun++;
        if ({bus.digit_valid, bus.hex_out} !== {4'b0001, 16'h0003} || framePulses != 0) begin
            testsFailed++;
            $display("[TB] FAIL single_hold: got valid=%b hex=%h pulses=%0d expected valid=0001 hex=0003 pulses=0",
                     bus.digit_valid, bus.hex_out, framePulses);
        end
    endtask

    task automatic test_frame();
        framePulses = 0;
        runSlot(4'b1110, 8'b1_0000001, SLOT);
        runSlot(4'b1101, 8'b1_1001111, SLOT);
        runSlot(4'b1011, 8'b1_0010010, SLOT);
        runSlot(4'b0111, 8'b1_0000110, SLOT);
        testsRun++;
        if (framePulses != 1) begin
            testsFailed++;
            $display("[TB] FAIL frame_pulses: got %0d expected 1", framePulses);
        end
        testsRun++;
        if (bus.hex_out !== 16'h3210) begin
            testsFailed++;
            $display("[TB] FAIL frame_hex: got %h expected 3210", bus.hex_out);
        end
        testsRun++;
        if (bus.digit_valid !== 4'b1111 || bus.dp_out !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL frame_valid_dp: got valid=%b dp=%b expected 1111/1111",
                     bus.digit_valid, bus.dp_out);
        end
        testsRun++;
        if (bus.hi_detect !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL frame_hi: got %b expected 0", bus.hi_detect);
        end
    endtask

    task automatic test_unstable();
        framePulses = 0;
        for (int i = 0; i < 8; i++) begin
            runSlot(4'b1101, (i % 2 == 0) ? 8'b1_0100100 : 8'b1_0100000, 8);
        end
        runSlot(4'b1111, 8'hFF, SLOT);
        testsRun++;
        if (bus.hex_out !== 16'h3210 || framePulses != 0) begin
            testsFailed++;
            $display("[TB] FAIL unstable_nocapture: got hex=%h pulses=%0d expected 3210/0",
                     bus.hex_out, framePulses);
        end
    endtask

    task automatic test_hi_frame();
        framePulses = 0;
        runSlot(4'b1110, 8'b1111_1111, SLOT);
        runSlot(4'b1101, 8'b1100_1111, SLOT);
        runSlot(4'b1011, 8'b1100_1000, SLOT);
        runSlot(4'b0111, 8'b1111_1111, SLOT);
        testsRun++;
        if (bus.hi_detect !== 1'b1 || framePulses != 1) begin
            testsFailed++;
            $display("[TB] FAIL hi_detect: got hi=%b pulses=%0d expected 1/1", bus.hi_detect, framePulses);
        end
        testsRun++;
        if (bus.is_h_out !== 4'b0100 || bus.blank_out !== 4'b1001) begin
            testsFailed++;
            $display("[TB] FAIL hi_glyphs: got is_h=%b blank=%b expected 0100/1001",
                     bus.is_h_out, bus.blank_out);
        end
        testsRun++;
        if (bus.digit_valid !== 4'b0010 || bus.hex_out !== 16'h3210 || bus.glyph_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hi_digits: got valid=%b hex=%h gerr=%b expected 0010/3210/0",
                     bus.digit_valid, bus.hex_out, bus.glyph_err);
        end
    endtask

    task automatic test_errors();
        runSlot(4'b1110, 8'b1_1111110, SLOT);
        testsRun++;
        if (bus.glyph_err !== 1'b1 || bus.an_err !== 1'b0 || bus.hex_out !== 16'h3210) begin
            testsFailed++;
            $display("[TB] FAIL err_glyph: got gerr=%b aerr=%b hex=%h expected 1/0/3210",
                     bus.glyph_err, bus.an_err, bus.hex_out);
        end
        runSlot(4'b1100, 8'b1_0000000, SLOT);
        testsRun++;
        if (bus.an_err !== 1'b1 || bus.hex_out !== 16'h3210) begin
            testsFailed++;
            $display("[TB] FAIL err_an: got aerr=%b hex=%h expected 1/3210", bus.an_err, bus.hex_out);
        end
        bus.clr_err = 1'b1;
        stepCycles(1);
        bus.clr_err = 1'b0;
        testsRun++;
        if (bus.glyph_err !== 1'b0 || bus.an_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_clear: got gerr=%b aerr=%b expected 0/0", bus.glyph_err, bus.an_err);
        end
        bus.an_in   = 4'b1010;
        bus.sseg_in = 8'hFF;
        bus.clr_err = 1'b1;
        stepCycles(SC + 1);
        testsRun++;
        if (bus.an_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_same_early: got %b expected 0", bus.an_err);
        end
        stepCycles(1);
        testsRun++;
        if (bus.an_err !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL err_same_cycle: got %b expected 1", bus.an_err);
        end
        stepCycles(1);
        testsRun++;
        if (bus.an_err !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL err_same_after: got %b expected 0", bus.an_err);
        end
        bus.clr_err = 1'b0;
    endtask

    task automatic test_timeout();
        framePulses = 0;
        runSlot(4'b1110, 8'b1_1001100, SLOT);
        runSlot(4'b1101, 8'b1_0100100, SLOT);
        runSlot(4'b1011, 8'b1_0100000, SLOT);
        runSlot(4'b0111, 8'b1_0001111, SLOT);
        testsRun++;
        if (framePulses != 1 || bus.hex_out !== 16'h7654 || bus.digit_valid !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL to_frame: got pulses=%0d hex=%h valid=%b expected 1/7654/1111",
                     framePulses, bus.hex_out, bus.digit_valid);
        end
        runSlot(4'b1111, 8'hFF, 200);
        testsRun++;
        if (bus.scan_timeout !== 1'b0 || bus.digit_valid !== 4'b1111) begin
            testsFailed++;
            $display("[TB] FAIL to_early: got timeout=%b valid=%b expected 0/1111",
                     bus.scan_timeout, bus.digit_valid);
        end
        stepCycles(100);
        testsRun++;
        if (bus.scan_timeout !== 1'b1 || bus.digit_valid !== 4'b0000 || bus.hi_detect !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL to_fire: got timeout=%b valid=%b hi=%b expected 1/0000/0",
                     bus.scan_timeout, bus.digit_valid, bus.hi_detect);
        end
        runSlot(4'b1011, 8'b1_0001000, SLOT);
        testsRun++;
        if (bus.scan_timeout !== 1'b0 || bus.digit_valid !== 4'b0100 || bus.hex_out !== 16'h7A54) begin
            testsFailed++;
            $display("[TB] FAIL to_recover: got timeout=%b valid=%b hex=%h expected 0/0100/7A54",
                     bus.scan_timeout, bus.digit_valid, bus.hex_out);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_frame();
        test_unstable();
        test_hi_frame();
        test_errors();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
